// File: rtl/rr_req_queue.sv
// Two-channel request queue feeding a 2-way round-robin arbiter; pops the granted head word.
// Optional rejected-push counter on drop_cnt is enabled by defining RRQ_DROP_CNT_EN.
module rr_req_queue #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       push,
    input  logic [WIDTH-1:0] din0,
    input  logic [WIDTH-1:0] din1,
    output logic [1:0]       full,
    output logic [1:0]       request,
    input  logic [1:0]       grant,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             dout_ch,
`ifdef RRQ_DROP_CNT_EN
    output logic [7:0]       drop_cnt,
`endif
    output logic             err_grant
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q    [2][DEPTH];
    logic [AW-1:0]    rd_ptr_q [2];
    logic [AW-1:0]    rd_ptr_d [2];
    logic [AW-1:0]    wr_ptr_q [2];
    logic [AW-1:0]    wr_ptr_d [2];
    logic [CW-1:0]    count_q  [2];
    logic [CW-1:0]    count_d  [2];
    logic [WIDTH-1:0] din      [2];

    logic [1:0]       push_ok;
    logic [1:0]       pop;
    logic             grant_both;

    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             dout_ch_q, dout_ch_d;
    logic             err_grant_q, err_grant_d;

    assign din[0] = din0;
    assign din[1] = din1;

    // Status decodes registered counts only, never the inputs.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            full[i]    = (count_q[i] == CW'(DEPTH));
            request[i] = (count_q[i] != '0);
        end
    end

    // A double grant is an arbiter fault: no pop, flag raised.
    always_comb begin
        grant_both = &grant;
        for (int i = 0; i < 2; i++) begin
            push_ok[i] = push[i] & ~full[i];
            pop[i]     = grant[i] & ~grant_both & request[i];
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            wr_ptr_d[i] = push_ok[i] ? wr_ptr_q[i] + AW'(1) : wr_ptr_q[i];
            rd_ptr_d[i] = pop[i]     ? rd_ptr_q[i] + AW'(1) : rd_ptr_q[i];
            count_d[i]  = count_q[i] + CW'(push_ok[i]) - CW'(pop[i]);
        end
    end

    always_comb begin
        dout_d       = dout_q;
        dout_ch_d    = dout_ch_q;
        dout_valid_d = |pop;
        err_grant_d  = err_grant_q | grant_both;
        if (pop[1]) begin
            dout_d    = mem_q[1][rd_ptr_q[1]];
            dout_ch_d = 1'b1;
        end else if (pop[0]) begin
            dout_d    = mem_q[0][rd_ptr_q[0]];
            dout_ch_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                rd_ptr_q[i] <= '0;
                wr_ptr_q[i] <= '0;
                count_q[i]  <= '0;
            end
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            dout_ch_q    <= 1'b0;
            err_grant_q  <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                rd_ptr_q[i] <= rd_ptr_d[i];
                wr_ptr_q[i] <= wr_ptr_d[i];
                count_q[i]  <= count_d[i];
            end
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            dout_ch_q    <= dout_ch_d;
            err_grant_q  <= err_grant_d;
        end
    end

    // Storage needs no reset; validity is tracked by the pointers and counts.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (push_ok[i]) begin
                mem_q[i][wr_ptr_q[i]] <= din[i];
            end
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign dout_ch    = dout_ch_q;
    assign err_grant  = err_grant_q;

`ifdef RRQ_DROP_CNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;
    logic [1:0] reject;
    logic [8:0] drop_sum;

    always_comb begin
        reject     = push & full;
        drop_sum   = {1'b0, drop_cnt_q} + 9'(reject[0]) + 9'(reject[1]);
        drop_cnt_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

endmodule
